// File: rtl/vect_pkg.sv
// Shared types and sizing for the vector lane packer.
package vect_pkg;
   localparam int unsigned LANE_W    = 8;
   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned VECT_W    = 32;
   localparam int unsigned IDX_W     = $clog2(NUM_LANES);

   typedef logic [IDX_W-1:0] lane_idx_t;

   typedef enum logic [1:0] {
      VP_IDLE,
      VP_COLLECT,
      VP_WRITE
   } vp_state_t;

   localparam lane_idx_t LAST_LANE = lane_idx_t'(NUM_LANES - 1);
endpackage

// File: rtl/vect_lane_sel.sv
// Next-enabled-lane finder: returns the lowest set bit of cand. Used only when
// the packer is built with VPACK_MASK_EN.
module vect_lane_sel
   import vect_pkg::*;
(
   input  logic [NUM_LANES-1:0] cand,
   output logic                 found,
   output lane_idx_t            idx
);
   always_comb begin
      found = 1'b0;
      idx   = '0;
      // Scan downwards so the lowest enabled lane is the last one to win.
      for (int unsigned i = NUM_LANES; i > 0; i--) begin
         if (cand[i-1]) begin
            found = 1'b1;
            idx   = lane_idx_t'(i - 1);
         end
      end
   end
endmodule

// File: rtl/vect_lane_packer.sv
// Packs NUM_LANES lane results (lane 0 in the MSB byte) into one vector word and
// strobes XWrite. Optional lane masking is enabled by defining VPACK_MASK_EN.
module vect_lane_packer
   import vect_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 flush,
   input  logic                 lane_valid,
   input  logic [LANE_W-1:0]    lane_data,
`ifdef VPACK_MASK_EN
   input  logic [NUM_LANES-1:0] lane_mask,
`endif
   output logic                 lane_ready,
   output logic [VECT_W-1:0]    vectoutwire,
   output logic                 XWrite,
   output logic                 busy,
   output logic                 done
);
   vp_state_t         state_q, state_d;
   lane_idx_t         lane_idx_q, lane_idx_d;
   logic [VECT_W-1:0] vect_q, vect_d;
   logic              lane_ready_q, lane_ready_d;
   logic              busy_q, busy_d;
   logic              xwrite_q, xwrite_d;
   logic              done_q, done_d;
   logic              accept;

`ifdef VPACK_MASK_EN
   logic [NUM_LANES-1:0] mask_q, mask_d;
   logic [NUM_LANES-1:0] sel_cand;
   logic                 sel_found;
   lane_idx_t            sel_idx;

   // From IDLE search the incoming mask; in COLLECT only lanes above the current one.
   always_comb begin
      sel_cand = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         if (state_q == VP_IDLE) sel_cand[i] = lane_mask[i];
         else                    sel_cand[i] = mask_q[i] && (lane_idx_t'(i) > lane_idx_q);
      end
   end

   vect_lane_sel u_sel (
      .cand  (sel_cand),
      .found (sel_found),
      .idx   (sel_idx)
   );
`endif

   assign accept = lane_valid && lane_ready_q;

   always_comb begin
      state_d    = state_q;
      lane_idx_d = lane_idx_q;
      vect_d     = vect_q;
      xwrite_d   = 1'b0;
      done_d     = 1'b0;
`ifdef VPACK_MASK_EN
      mask_d     = mask_q;
`endif
      case (state_q)
         VP_IDLE: begin
            if (!flush && start) begin
               vect_d     = '0;
               lane_idx_d = '0;
`ifdef VPACK_MASK_EN
               mask_d = lane_mask;
               if (sel_found) begin
                  lane_idx_d = sel_idx;
                  state_d    = VP_COLLECT;
               end else begin
                  state_d = VP_WRITE;
                  done_d  = 1'b1;
               end
`else
               state_d = VP_COLLECT;
`endif
            end
         end
         VP_COLLECT: begin
            if (flush) begin
               state_d    = VP_IDLE;
               lane_idx_d = '0;
            end else if (accept) begin
               for (int unsigned i = 0; i < NUM_LANES; i++) begin
                  if (lane_idx_t'(i) == lane_idx_q)
                     vect_d[(NUM_LANES-1-i)*LANE_W +: LANE_W] = lane_data;
               end
`ifdef VPACK_MASK_EN
               if (sel_found) begin
                  lane_idx_d = sel_idx;
               end else begin
                  state_d    = VP_WRITE;
                  lane_idx_d = '0;
                  xwrite_d   = 1'b1;
                  done_d     = 1'b1;
               end
`else
               if (lane_idx_q == LAST_LANE) begin
                  state_d    = VP_WRITE;
                  lane_idx_d = '0;
                  xwrite_d   = 1'b1;
                  done_d     = 1'b1;
               end else begin
                  lane_idx_d = lane_idx_q + lane_idx_t'(1);
               end
`endif
            end
         end
         default: begin
            state_d    = VP_IDLE;
            lane_idx_d = '0;
         end
      endcase
      lane_ready_d = (state_d == VP_COLLECT);
      busy_d       = (state_d != VP_IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= VP_IDLE;
         lane_idx_q   <= '0;
         vect_q       <= '0;
         lane_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         xwrite_q     <= 1'b0;
         done_q       <= 1'b0;
`ifdef VPACK_MASK_EN
         mask_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         lane_idx_q   <= lane_idx_d;
         vect_q       <= vect_d;
         lane_ready_q <= lane_ready_d;
         busy_q       <= busy_d;
         xwrite_q     <= xwrite_d;
         done_q       <= done_d;
`ifdef VPACK_MASK_EN
         mask_q       <= mask_d;
`endif
      end
   end

   // A flush arriving during the WRITE cycle must still cancel that cycle's strobes.
   assign XWrite      = xwrite_q && !flush;
   assign done        = done_q && !flush;
   assign lane_ready  = lane_ready_q;
   assign busy        = busy_q;
   assign vectoutwire = vect_q;
endmodule

// File: tb/tb_vect_lane_packer.sv
// Self-checking bench for vect_lane_packer: table-driven packs plus corner-case sequences.
module tb_vect_lane_packer;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic        lane_valid = 1'b0;
   logic [7:0]  lane_data = '0;
`ifdef VPACK_MASK_EN
   logic [3:0]  lane_mask = 4'hF;
`endif
   logic        lane_ready;
   logic [31:0] vectoutwire;
   logic        XWrite;
   logic        busy;
   logic        done;

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic [31:0] sb[$];

   typedef struct {
      logic [7:0]  lanes [4];
      int unsigned gap   [4];
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [4];

   always #5 clock = ~clock;

   vect_lane_packer dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .flush       (flush),
      .lane_valid  (lane_valid),
      .lane_data   (lane_data),
`ifdef VPACK_MASK_EN
      .lane_mask   (lane_mask),
`endif
      .lane_ready  (lane_ready),
      .vectoutwire (vectoutwire),
      .XWrite      (XWrite),
      .busy        (busy),
      .done        (done)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Scoreboard: every XWrite consumes one expected word.
   always @(negedge clock) begin
      if (!reset && XWrite) begin
         if (sb.size() == 0) begin
            chk("xwrite_unexpected", 32'd1, 32'd0);
         end else begin
            logic [31:0] e;
            e = sb.pop_front();
            chk("sb_word", vectoutwire, e);
            chk("sb_done", {31'd0, done}, 32'd1);
         end
      end
   end

   function automatic vec_t mk(input logic [7:0] l0, l1, l2, l3,
                               input int unsigned g0, g1, g2, g3,
                               input logic [31:0] exp);
      vec_t v;
      v.lanes[0] = l0; v.lanes[1] = l1; v.lanes[2] = l2; v.lanes[3] = l3;
      v.gap[0] = g0; v.gap[1] = g1; v.gap[2] = g2; v.gap[3] = g3;
      v.exp = exp;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input string nm, input bit flush_in_write);
      int unsigned n;
      int unsigned gsum;
      n = 0;
      gsum = 0;
      start = 1'b1;
      step(); n++;
      start = 1'b0;
      chk({nm, "_ready"}, {31'd0, lane_ready}, 32'd1);
      chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
      for (int unsigned k = 0; k < 4; k++) begin
         for (int unsigned g = 0; g < v.gap[k]; g++) begin
            step(); n++; gsum++;
            chk({nm, "_gap_ready"}, {31'd0, lane_ready}, 32'd1);
            chk({nm, "_gap_xw"}, {31'd0, XWrite}, 32'd0);
         end
         lane_valid = 1'b1;
         lane_data  = v.lanes[k];
         if (k == 3 && !flush_in_write) sb.push_back(v.exp);
         step(); n++;
         lane_valid = 1'b0;
         if (k < 3) chk({nm, "_early_xw"}, {31'd0, XWrite}, 32'd0);
      end
      if (flush_in_write) begin
         flush = 1'b1;
         #1;
         chk({nm, "_fiw_xw"}, {31'd0, XWrite}, 32'd0);
         chk({nm, "_fiw_done"}, {31'd0, done}, 32'd0);
         step();
         flush = 1'b0;
         chk({nm, "_fiw_busy"}, {31'd0, busy}, 32'd0);
      end else begin
         chk({nm, "_latency"}, n, 5 + gsum);
         chk({nm, "_xw"}, {31'd0, XWrite}, 32'd1);
         chk({nm, "_done"}, {31'd0, done}, 32'd1);
         chk({nm, "_ready_wr"}, {31'd0, lane_ready}, 32'd0);
         chk({nm, "_word"}, vectoutwire, v.exp);
         step();
         chk({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
         chk({nm, "_xw_after"}, {31'd0, XWrite}, 32'd0);
         chk({nm, "_hold"}, vectoutwire, v.exp);
      end
   endtask

   task automatic feed(input logic [7:0] d);
      lane_valid = 1'b1;
      lane_data  = d;
      step();
      lane_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0] = mk(8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0, 32'h11223344);
      tbl[1] = mk(8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 1, 2, 3, 32'hA1B2C3D4);
      tbl[2] = mk(8'hFF, 8'h00, 8'h80, 8'h7F, 3, 0, 0, 1, 32'hFF00807F);
      tbl[3] = mk(8'h00, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0, 32'h00000001);

      // Reset held two cycles
      reset = 1'b1;
      step(); step();
      chk("rst_vect", vectoutwire, 32'h0);
      chk("rst_xw", {31'd0, XWrite}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_ready", {31'd0, lane_ready}, 32'd0);
      reset = 1'b0;
      step();

      for (int unsigned i = 0; i < 4; i++) run_vec(tbl[i], $sformatf("vec%0d", i), 1'b0);

      // Flush after two lanes, with a third lane dropped in the flush cycle
      start = 1'b1; step(); start = 1'b0;
      feed(8'h0B); feed(8'h0C);
      flush = 1'b1; lane_valid = 1'b1; lane_data = 8'h0D;
      step();
      flush = 1'b0; lane_valid = 1'b0;
      chk("flush_busy", {31'd0, busy}, 32'd0);
      chk("flush_ready", {31'd0, lane_ready}, 32'd0);
      chk("flush_partial", vectoutwire, 32'h0B0C0000);
      step();
      chk("flush_xw", {31'd0, XWrite}, 32'd0);
      run_vec(mk(8'h01, 8'h02, 8'h03, 8'h04, 0, 0, 0, 0, 32'h01020304), "post_flush", 1'b0);

      // Flush during WRITE suppresses the strobe
      run_vec(mk(8'h5A, 8'h6B, 8'h7C, 8'h8D, 0, 0, 0, 0, 32'h5A6B7C8D), "fiw", 1'b1);

      // start and flush together in IDLE: flush wins
      start = 1'b1; flush = 1'b1;
      step();
      start = 1'b0; flush = 1'b0;
      chk("sf_busy", {31'd0, busy}, 32'd0);
      chk("sf_ready", {31'd0, lane_ready}, 32'd0);

      // Reset mid-pack after three lanes
      start = 1'b1; step(); start = 1'b0;
      feed(8'h99); feed(8'h88); feed(8'h77);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_vect", vectoutwire, 32'h0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_ready", {31'd0, lane_ready}, 32'd0);
      step();
      chk("midrst_xw", {31'd0, XWrite}, 32'd0);

      // start held during WRITE is ignored
      start = 1'b1; step(); start = 1'b0;
      feed(8'hDE); feed(8'hAD); feed(8'hBE);
      sb.push_back(32'hDEADBEEF);
      feed(8'hEF);
      chk("sdw_xw", {31'd0, XWrite}, 32'd1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("sdw_busy", {31'd0, busy}, 32'd0);
      chk("sdw_ready", {31'd0, lane_ready}, 32'd0);
      step();
      chk("sdw_busy2", {31'd0, busy}, 32'd0);
      chk("sdw_hold", vectoutwire, 32'hDEADBEEF);

`ifdef VPACK_MASK_EN
      // Lanes 0 and 2 enabled
      lane_mask = 4'b0101;
      start = 1'b1; step(); start = 1'b0;
      chk("mask_ready", {31'd0, lane_ready}, 32'd1);
      feed(8'hAA);
      sb.push_back(32'hAA00CC00);
      feed(8'hCC);
      chk("mask_xw", {31'd0, XWrite}, 32'd1);
      chk("mask_word", vectoutwire, 32'hAA00CC00);
      step();
      // Empty mask completes without a register write
      lane_mask = 4'b0000;
      start = 1'b1; step(); start = 1'b0;
      chk("empty_done", {31'd0, done}, 32'd1);
      chk("empty_xw", {31'd0, XWrite}, 32'd0);
      step();
      chk("empty_busy", {31'd0, busy}, 32'd0);
      lane_mask = 4'hF;
`endif

      step();
      chk("sb_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
